// File: rtl/rca_seq_seg.sv
// Sequential ripple-carry adder/subtractor: one SEG_W-bit segment per clock, LSB segment first.
// Latency: out_valid rises NSEG edges after the accept edge; minimum issue interval NSEG+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE, in_valid ignored otherwise.
// Optional macro RCA_SEQ_OVF_EN adds the registered two's-complement overflow output ovf.
module rca_seq_seg #(
    parameter int WIDTH = 80,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef RCA_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    // Reject splits that do not tile the operand exactly.
    if (SEG_W < 1 || (WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_split
        $error("rca_seq_seg: WIDTH must be a positive integer multiple of SEG_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;       // already inverted for subtract
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               last_seg;
    logic [SEG_W-1:0]   a_seg;
    logic [SEG_W-1:0]   b_seg;
    logic [SEG_W:0]     seg_res;   // {carry out, segment sum}

    assign last_seg = (idx == IDX_W'(NSEG - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_seg) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the current segment of each operand and add it with the running carry.
    always_comb begin
        a_seg = '0;
        b_seg = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (idx == IDX_W'(k)) begin
                a_seg = a_q[k*SEG_W +: SEG_W];
                b_seg = b_q[k*SEG_W +: SEG_W];
            end
        end
        seg_res = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, carry};
    end

    // Operand capture on accept, then one segment per RUN cycle; final carry latched on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NSEG; k++) begin
                        if (idx == IDX_W'(k)) begin
                            sum[k*SEG_W +: SEG_W] <= seg_res[SEG_W-1:0];
                        end
                    end
                    carry <= seg_res[SEG_W];
                    idx   <= idx + 1'b1;
                    if (last_seg) begin
                        cout <= seg_res[SEG_W];
`ifdef RCA_SEQ_OVF_EN
                        // Carry into the MSB recovered from the MSB sum bit, compared with carry out.
                        ovf  <= (a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ seg_res[SEG_W-1]) ^ seg_res[SEG_W];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
